mem_port_arbiter: RTL

Shares the single-port unified memory between instruction fetch (IF) and the data-memory stage (MEM) of the 5-stage MIPS pipeline. It arbitrates and sequences each access and formats store byte lanes. It produces per-requester stalls and a global pipeline enable that drives the `mem_en` / `pc_en` / `ir_en` style enables of every pipeline register.

---
 rtl/mem_arb_pkg.sv | 8 +
 rtl/dm_lane_gen.sv | 24 ++
 rtl/mem_port_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, size codes and byte-enable constants for the memory port arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, DM_ACC, IF_ACC} state_t;
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [3:0] BE_ALL = 4'b1111;
endpackage

// File: rtl/dm_lane_gen.sv
// dm_lane_gen: byte enables, lane-replicated store data and misalignment flag for a MEM-stage access
module dm_lane_gen
    import mem_arb_pkg::*;
(
    input  logic        i_we,
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic        o_misalign
);
    logic w_byte;
    logic w_half;

    // Size code 3 falls through every byte/half test and so behaves as a word
    always_comb begin
        w_byte = i_size == SZ_BYTE;
        w_half = i_size == SZ_HALF;
        o_be = !i_we ? BE_ALL : w_byte ? 4'b0001 << i_addr_lo : w_half ? (i_addr_lo[1] ? 4'b1100 : 4'b0011) : BE_ALL;
        o_wdata = w_byte ? {4{i_wdata[7:0]}} : w_half ? {2{i_wdata[15:0]}} : i_wdata;
        o_misalign = w_half ? i_addr_lo[0] : !w_byte && (i_addr_lo != 2'b00);
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and MEM stage, MEM first, with stalls and pipeline enable
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [1:0]        dm_size,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic [31:0]       dm_rdata,
    output logic              dm_stall,
    output logic              pipe_en,
    output logic              misalign_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready
);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_dm_done;
    logic              r_if_done;
    logic              r_misalign;
    logic              r_mem_we;
    logic [3:0]        r_mem_be;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic [31:0]       r_if_rdata;
    logic [31:0]       r_dm_rdata;
    logic              w_free;
    logic              w_dm_pend;
    logic              w_if_pend;
    logic              w_go_dm;
    logic              w_go_if;
    logic              w_mis_hit;
    logic              w_misalign;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;

    dm_lane_gen u_lane (
        .i_we       (dm_we),
        .i_size     (dm_size),
        .i_addr_lo  (dm_addr[1:0]),
        .i_wdata    (dm_wdata),
        .o_be       (w_be),
        .o_wdata    (w_wdata),
        .o_misalign (w_misalign)
    );

    assign if_stall     = if_req && !r_if_done;
    assign dm_stall     = dm_req && !r_dm_done;
    assign pipe_en      = !(if_stall || dm_stall);
    assign mem_req      = r_state != IDLE;
    assign mem_we       = r_mem_we;
    assign mem_be       = r_mem_be;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign if_rdata     = r_if_rdata;
    assign dm_rdata     = r_dm_rdata;
    assign misalign_err = r_misalign;

    // When the port is free, launch MEM first; a misaligned MEM access is retired without touching memory
    always_comb begin
        w_free      = (r_state == IDLE) || mem_ready;
        w_dm_pend   = dm_stall && (r_state != DM_ACC);
        w_if_pend   = if_stall && (r_state != IF_ACC);
        w_go_dm     = w_free && w_dm_pend && !w_misalign;
        w_mis_hit   = w_free && w_dm_pend && w_misalign;
        w_go_if     = w_free && w_if_pend && !w_go_dm;
        w_state_nxt = w_go_dm ? DM_ACC : w_go_if ? IF_ACC : w_free ? IDLE : r_state;
    end

    // State register and done flags; done flags hold until the pipeline advances
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_dm_done  <= 1'b0;
            r_if_done  <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_misalign <= w_mis_hit;
            r_dm_done  <= !pipe_en && (r_dm_done || w_mis_hit || (r_state == DM_ACC && mem_ready));
            r_if_done  <= !pipe_en && (r_if_done || (r_state == IF_ACC && mem_ready));
        end
    end

    // Latch the launched request so the memory sees stable fields until mem_ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_we    <= 1'b0;
            r_mem_be    <= 4'b0000;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (w_go_dm) begin
            r_mem_we    <= dm_we;
            r_mem_be    <= w_be;
            r_mem_addr  <= dm_addr & ALIGN_MASK;
            r_mem_wdata <= w_wdata;
        end else if (w_go_if) begin
            r_mem_we    <= 1'b0;
            r_mem_be    <= BE_ALL;
            r_mem_addr  <= if_addr & ALIGN_MASK;
            r_mem_wdata <= '0;
        end
    end

    // Capture returned words for completed loads and fetches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else begin
            if (mem_ready && r_state == DM_ACC && !r_mem_we) r_dm_rdata <= mem_rdata;
            if (mem_ready && r_state == IF_ACC) r_if_rdata <= mem_rdata;
        end
    end
endmodule
